opb_register_simulink2ppc: RTL and testbench

Fabric-to-processor status register on the OPB bus: captures a 32-bit word from user logic on a valid strobe and lets the PowerPC read it back, along with an update counter, a new-data flag and an overrun flag. It is the read-side counterpart of the processor-to-fabric OPB register, and is instantiated per yellow-block readback register behind a generated wrapper. The block has a single clock domain (OPB), and user logic drives it synchronously to OPB_Clk.

---
 rtl/opb_register_simulink2ppc.sv | 150 +++++++++++++++
 tb/tb_opb_register_simulink2ppc.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_register_simulink2ppc.sv
// Fabric-to-PowerPC OPB readback register: captures a user word on a valid strobe
// and exposes it with an update counter, new-data flag and sticky overrun flag.
module opb_register_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR   = 32'hFFFF_FFFF,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_0000,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst,
    output logic [0:31] Sl_DBus,
    output logic        Sl_errAck,
    output logic        Sl_retry,
    output logic        Sl_toutSup,
    output logic        Sl_xferAck,
    input  logic [0:31] OPB_ABus,
    input  logic [0:3]  OPB_BE,
    input  logic [0:31] OPB_DBus,
    input  logic        OPB_RNW,
    input  logic        OPB_select,
    input  logic        OPB_seqAddr,
    input  logic [31:0] user_data_in,
    input  logic        user_valid
);

    localparam logic [5:0] OFF_DATA   = 6'd0;
    localparam logic [5:0] OFF_STATUS = 6'd1;
    localparam logic [5:0] OFF_CTRL   = 6'd2;

    // Width/family parameters are informational; the datapath is fixed at 32 bits.
    localparam int unused_cfg = C_OPB_AWIDTH + C_OPB_DWIDTH + $bits(C_FAMILY);

    typedef enum logic {
        IDLE,
        ACK
    } state_t;

    state_t      state;
    logic [31:0] shadow;
    logic [15:0] update_count;
    logic        new_flag;
    logic        overrun;
    logic        freeze;

    logic [5:0]  lat_offset;
    logic        lat_rnw;
    logic        lat_be3;
    logic [1:0]  lat_wdata;

    logic        hit;
    logic [5:0]  offset;
    logic [31:0] rd_word;
    logic        capture;
    logic        data_rd_ack;
    logic        ovr_clr;
    logic        ctrl_wr;
    logic        unused_bits;

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    always_comb begin
        unused_bits = ^{OPB_seqAddr, OPB_ABus[30:31], OPB_BE[0:2], OPB_DBus[0:29]};
    end

    always_comb begin
        offset = OPB_ABus[24:29];
        hit    = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    end

    // Read data is chosen from the live address in IDLE and registered into the ack cycle.
    always_comb begin
        rd_word = '0;
        case (offset)
            OFF_DATA:   rd_word = shadow;
            OFF_STATUS: rd_word = {update_count, 14'b0, overrun, new_flag};
            OFF_CTRL:   rd_word = {31'b0, freeze};
            default:    rd_word = '0;
        endcase
    end

    always_comb begin
        capture     = user_valid && !freeze;
        data_rd_ack = (state == ACK) && lat_rnw && (lat_offset == OFF_DATA);
        ovr_clr     = (state == ACK) && !lat_rnw && (lat_offset == OFF_STATUS)
                      && lat_be3 && lat_wdata[1];
        ctrl_wr     = (state == ACK) && !lat_rnw && (lat_offset == OFF_CTRL) && lat_be3;
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state        <= IDLE;
            Sl_xferAck   <= 1'b0;
            Sl_DBus      <= '0;
            shadow       <= '0;
            update_count <= '0;
            new_flag     <= 1'b0;
            overrun      <= 1'b0;
            freeze       <= 1'b0;
            lat_offset   <= '0;
            lat_rnw      <= 1'b0;
            lat_be3      <= 1'b0;
            lat_wdata    <= '0;
        end else begin
            Sl_xferAck <= 1'b0;
            Sl_DBus    <= '0;

            case (state)
                IDLE: begin
                    if (hit) begin
                        lat_offset <= offset;
                        lat_rnw    <= OPB_RNW;
                        lat_be3    <= OPB_BE[3];
                        lat_wdata  <= OPB_DBus[30:31];
                        Sl_xferAck <= 1'b1;
                        if (OPB_RNW) begin
                            Sl_DBus <= rd_word;
                        end
                        state <= ACK;
                    end
                end
                ACK: begin
                    if (ctrl_wr) begin
                        freeze <= lat_wdata[0];
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A capture outranks a same-cycle DATA-read clear of new_flag.
            if (capture) begin
                shadow       <= user_data_in;
                update_count <= update_count + 16'd1;
                new_flag     <= 1'b1;
            end else if (data_rd_ack) begin
                new_flag <= 1'b0;
            end

            if (capture && new_flag && !data_rd_ack) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Directed bench for opb_register_simulink2ppc: bus reads/writes with a queue of
// expected ack data, plus capture, freeze, overrun, wrap and reset-abort cases.
module tb_opb_register_simulink2ppc;

    localparam logic [31:0] BASE    = 32'h8000_0000;
    localparam logic [31:0] HIGH    = 32'h8000_00FF;
    localparam logic [31:0] A_DATA  = BASE + 32'h0;
    localparam logic [31:0] A_STAT  = BASE + 32'h4;
    localparam logic [31:0] A_CTRL  = BASE + 32'h8;

    logic        clk;
    logic        OPB_Rst;
    logic [0:31] Sl_DBus;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;
    logic        Sl_xferAck;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [31:0] user_data_in;
    logic        user_valid;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    opb_register_simulink2ppc #(
        .C_BASEADDR (BASE),
        .C_HIGHADDR (HIGH)
    ) dut (
        .OPB_Clk      (clk),
        .OPB_Rst      (OPB_Rst),
        .Sl_DBus      (Sl_DBus),
        .Sl_errAck    (Sl_errAck),
        .Sl_retry     (Sl_retry),
        .Sl_toutSup   (Sl_toutSup),
        .Sl_xferAck   (Sl_xferAck),
        .OPB_ABus     (OPB_ABus),
        .OPB_BE       (OPB_BE),
        .OPB_DBus     (OPB_DBus),
        .OPB_RNW      (OPB_RNW),
        .OPB_select   (OPB_select),
        .OPB_seqAddr  (OPB_seqAddr),
        .user_data_in (user_data_in),
        .user_valid   (user_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called #1 after the edge that sampled the hit; optionally fires a capture in the ack cycle.
    task automatic collect_ack(input bit cap_in_ack, input logic [31:0] cap_d);
        logic [31:0] rd;
        logic [31:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, "_ack"}, {31'b0, Sl_xferAck}, 32'd1);
        rd = Sl_DBus;
        check({t, "_data"}, rd, e);
        if (cap_in_ack) begin
            user_data_in = cap_d;
            user_valid   = 1'b1;
        end
        @(posedge clk); #1;
        user_valid = 1'b0;
        check({t, "_ackdrop"}, {31'b0, Sl_xferAck}, 32'd0);
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string tag,
                            input bit cap_in_ack = 1'b0, input logic [31:0] cap_d = '0);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        OPB_ABus   = addr;
        OPB_RNW    = 1'b1;
        OPB_BE     = 4'hF;
        OPB_select = 1'b1;
        @(posedge clk); #1;
        OPB_select = 1'b0;
        collect_ack(cap_in_ack, cap_d);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] be,
                             input string tag, input bit cap_in_ack = 1'b0,
                             input logic [31:0] cap_d = '0);
        exp_q.push_back('0);
        tag_q.push_back(tag);
        OPB_ABus   = addr;
        OPB_DBus   = d;
        OPB_BE     = be;
        OPB_RNW    = 1'b0;
        OPB_select = 1'b1;
        @(posedge clk); #1;
        OPB_select = 1'b0;
        collect_ack(cap_in_ack, cap_d);
    endtask

    task automatic cap(input logic [31:0] d);
        user_data_in = d;
        user_valid   = 1'b1;
        @(posedge clk); #1;
        user_valid = 1'b0;
    endtask

    task automatic do_reset();
        OPB_Rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        OPB_Rst = 1'b0;
    endtask

    initial begin
        OPB_Rst      = 1'b1;
        OPB_ABus     = '0;
        OPB_BE       = '0;
        OPB_DBus     = '0;
        OPB_RNW      = 1'b0;
        OPB_select   = 1'b0;
        OPB_seqAddr  = 1'b0;
        user_data_in = '0;
        user_valid   = 1'b0;
        do_reset();

        check("rst_ack", {31'b0, Sl_xferAck}, 32'd0);
        check("rst_dbus", Sl_DBus, 32'd0);
        check("ties", {29'b0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'd0);
        bus_read(A_DATA, 32'h0000_0000, "rst_data");
        bus_read(A_STAT, 32'h0000_0000, "rst_status");

        cap(32'hDEAD_BEEF);
        bus_read(A_STAT, 32'h0001_0001, "cap1_status");
        bus_read(A_DATA, 32'hDEAD_BEEF, "cap1_data");
        bus_read(A_STAT, 32'h0001_0000, "cap1_status_clr");

        do_reset();
        cap(32'h1);
        cap(32'h2);
        bus_read(A_STAT, 32'h0002_0003, "ovr_status");
        bus_write(A_STAT, 32'h2, 4'b1110, "ovr_clr_nobe");
        bus_read(A_STAT, 32'h0002_0003, "ovr_kept");
        bus_write(A_STAT, 32'h2, 4'b1111, "ovr_clr");
        bus_read(A_STAT, 32'h0002_0001, "ovr_cleared");

        bus_write(A_CTRL, 32'h1, 4'b1111, "frz_on");
        bus_read(A_CTRL, 32'h0000_0001, "frz_ctrl");
        cap(32'h55);
        bus_read(A_DATA, 32'h0000_0002, "frz_data");
        bus_read(A_STAT, 32'h0002_0000, "frz_status");
        bus_write(A_CTRL, 32'h0, 4'b1111, "frz_off");
        bus_write(A_CTRL, 32'h1, 4'b1110, "frz_nobe");
        bus_read(A_CTRL, 32'h0000_0000, "frz_ctrl_off");
        cap(32'h77);
        bus_read(A_STAT, 32'h0003_0001, "unfrz_status");

        // Select held high: acks must alternate, never two in a row.
        OPB_ABus   = A_STAT;
        OPB_RNW    = 1'b1;
        OPB_BE     = 4'hF;
        OPB_select = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("b2b_ack", {31'b0, Sl_xferAck}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("b2b_data", Sl_DBus, (k % 2 == 0) ? 32'h0003_0001 : 32'h0);
        end
        OPB_select = 1'b0;
        @(posedge clk); #1;
        bus_read(A_DATA, 32'h0000_0077, "unfrz_data");

        bus_read(BASE + 32'h10, 32'h0, "unmapped_rd");
        bus_write(BASE + 32'h10, 32'hFFFF_FFFF, 4'hF, "unmapped_wr");
        bus_read(BASE + 32'hFC, 32'h0, "window_top");
        OPB_ABus   = BASE + 32'h100;
        OPB_RNW    = 1'b1;
        OPB_select = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("above_window", {31'b0, Sl_xferAck}, 32'd0);
        end
        OPB_ABus = BASE - 32'h4;
        repeat (2) begin
            @(posedge clk); #1;
            check("below_window", {31'b0, Sl_xferAck}, 32'd0);
        end
        OPB_select = 1'b0;

        do_reset();
        user_data_in = 32'h0;
        user_valid   = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            user_data_in = i;
            @(posedge clk); #1;
        end
        user_valid = 1'b0;
        bus_read(A_STAT, 32'hFFFF_0003, "wrap_ffff");
        cap(32'hABCD_0000);
        bus_read(A_STAT, 32'h0000_0003, "wrap_zero");
        bus_read(A_DATA, 32'hABCD_0000, "wrap_data");
        bus_write(A_STAT, 32'h2, 4'hF, "wrap_ovr_clr");
        bus_read(A_STAT, 32'h0000_0000, "wrap_clean");

        cap(32'h11);
        bus_read(A_DATA, 32'h0000_0011, "align_rd", 1'b1, 32'hCAFE_F00D);
        bus_read(A_STAT, 32'h0002_0001, "align_rd_status");
        bus_read(A_DATA, 32'hCAFE_F00D, "align_rd_data");
        cap(32'h20);
        cap(32'h21);
        bus_write(A_STAT, 32'h2, 4'hF, "align_clr", 1'b1, 32'h22);
        bus_read(A_STAT, 32'h0005_0003, "align_clr_status");

        // Reset lands on the edge ending the ack cycle: the transfer is dropped.
        bus_write(A_CTRL, 32'h1, 4'hF, "pre_rst_frz");
        OPB_ABus   = A_STAT;
        OPB_RNW    = 1'b1;
        OPB_BE     = 4'hF;
        OPB_select = 1'b1;
        @(posedge clk); #1;
        OPB_select = 1'b0;
        check("mid_ack", {31'b0, Sl_xferAck}, 32'd1);
        OPB_Rst = 1'b1;
        @(posedge clk); #1;
        OPB_Rst = 1'b0;
        check("mid_rst_ack", {31'b0, Sl_xferAck}, 32'd0);
        check("mid_rst_dbus", Sl_DBus, 32'd0);
        @(posedge clk); #1;
        check("mid_rst_ack2", {31'b0, Sl_xferAck}, 32'd0);
        bus_read(A_DATA, 32'h0, "post_rst_data");
        bus_read(A_STAT, 32'h0, "post_rst_status");
        bus_read(A_CTRL, 32'h0, "post_rst_ctrl");
        cap(32'h99);
        bus_read(A_STAT, 32'h0001_0001, "post_rst_cap");

        check("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
